// File: rtl/dot_product_pkg.sv
// Shared types for the streaming dot-product unit: control states, the tag
// that travels beside each product, and the default multiplier latency.
package dot_product_pkg;

  localparam int DEFAULT_LATENCY = 3;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

endpackage : dot_product_pkg

// File: rtl/mac_tag_pipe.sv
// Delay line of {valid, last} tags whose depth matches the multiplier latency,
// so the tap qualifies whatever product the multiplier presents that cycle.
module mac_tag_pipe
  import dot_product_pkg::*;
#(
  parameter int DEPTH = DEFAULT_LATENCY
) (
  input  logic clk,
  input  logic rst,
  input  tag_t i_tag,
  output tag_t o_tag
);

  tag_t r_pipe [DEPTH];

  // NOTE: unlike the multiplier's product registers, every tag stage is reset;
  // the zero tags are what hide the multiplier's stale contents after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_tag = r_pipe[DEPTH-1];

endmodule : mac_tag_pipe

// File: rtl/dot_product_accumulator.sv
// Streaming dot-product front/back end around an external pipelined multiplier:
// accepts operand pairs, tags them through the multiplier latency, sums products.
module dot_product_accumulator
  import dot_product_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int GUARD   = 8,
  parameter int CNT_W   = 16,
  localparam int ACC_W  = 2*WIDTH + GUARD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_last,
  output logic [WIDTH-1:0]   mult_a,
  output logic [WIDTH-1:0]   mult_b,
  input  logic [2*WIDTH-1:0] mult_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_data,
  output logic [CNT_W-1:0]   out_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_beats;

  logic             w_in_fire;
  tag_t             w_tag_in;
  tag_t             w_tap;
  logic [ACC_W-1:0] w_acc_sum;
  logic [CNT_W-1:0] w_beats_next;

  assign in_ready  = (r_state == ACCUM);
  assign w_in_fire = in_valid & in_ready;

  // Idle cycles feed zeros so the multiplier never sees unaccepted operands.
  assign mult_a = w_in_fire ? in_a : '0;
  assign mult_b = w_in_fire ? in_b : '0;

  assign w_tag_in.valid = w_in_fire;
  assign w_tag_in.last  = w_in_fire & in_last;

  mac_tag_pipe #(
    .DEPTH (LATENCY)
  ) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .i_tag (w_tag_in),
    .o_tag (w_tap)
  );

  assign w_acc_sum    = r_acc + {{GUARD{1'b0}}, mult_y};
  assign w_beats_next = (r_beats == CNT_MAX) ? r_beats : r_beats + CNT_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_beats   <= '0;
      out_data  <= '0;
      out_count <= '0;
    end else if (w_tap.valid) begin
      if (w_tap.last) begin
        out_data  <= w_acc_sum;
        out_count <= w_beats_next;
        r_acc     <= '0;
        r_beats   <= '0;
      end else begin
        r_acc   <= w_acc_sum;
        r_beats <= w_beats_next;
      end
    end
  end

  // One vector in flight: stop accepting after its last beat until the
  // result has been handed off downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ACCUM;
      out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        ACCUM: begin
          if (w_in_fire && in_last) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_tap.valid && w_tap.last) begin
            r_state   <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state   <= ACCUM;
            out_valid <= 1'b0;
          end
        end
        default: begin
          r_state   <= ACCUM;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule : dot_product_accumulator

// File: tb/tb_dot_product_accumulator.sv
// Directed bench for dot_product_accumulator with a 3-stage unreset multiplier
// model standing beside the DUT, as it would at the top level.
module tb_dot_product_accumulator;

  localparam int WIDTH = 8;
  localparam int ACC_W = 24;
  localparam int CNT_W = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_last;
  logic [WIDTH-1:0]   mult_a;
  logic [WIDTH-1:0]   mult_b;
  logic [2*WIDTH-1:0] mult_y;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_data;
  logic [CNT_W-1:0]   out_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dot_product_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .mult_a    (mult_a),
    .mult_b    (mult_b),
    .mult_y    (mult_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  // Multiplier model: three register stages, no reset, preloaded with junk.
  logic [2*WIDTH-1:0] m_s1 = 16'hBEEF;
  logic [2*WIDTH-1:0] m_s2 = 16'hDEAD;
  logic [2*WIDTH-1:0] m_s3 = 16'hCAFE;
  always_ff @(posedge clk) begin
    m_s1 <= mult_a * mult_b;
    m_s2 <= m_s1;
    m_s3 <= m_s2;
  end
  assign mult_y = m_s3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one pair and returns #1 after the edge at which it was accepted.
  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_result(input string name);
    int n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    if (!out_valid) check(name, 32'(out_valid), 32'd1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  a [4];
    logic [7:0]  b [4];
    int          len;
    logic [23:0] exp_data;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{a: '{8'd1, 8'd2, 8'd3, 8'd4},   b: '{8'd1, 8'd2, 8'd3, 8'd4}, len: 4, exp_data: 24'd30,    exp_cnt: 16'd4};
    vecs[1] = '{a: '{8'd10, 8'd20, 8'd0, 8'd0}, b: '{8'd3, 8'd4, 8'd0, 8'd0}, len: 2, exp_data: 24'd110,   exp_cnt: 16'd2};
    vecs[2] = '{a: '{8'd255, 8'd0, 8'd0, 8'd0}, b: '{8'd255, 8'd0, 8'd0, 8'd0}, len: 1, exp_data: 24'd65025, exp_cnt: 16'd1};
    vecs[3] = '{a: '{8'd0, 8'd0, 8'd7, 8'd0},   b: '{8'd9, 8'd9, 8'd9, 8'd0}, len: 3, exp_data: 24'd63,    exp_cnt: 16'd3};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    check("reset_in_ready",  32'(in_ready),  32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data",  32'(out_data),  32'd0);
    check("reset_out_count", 32'(out_count), 32'd0);

    // Single beat 3x5: out_valid rises exactly three edges after acceptance.
    send_beat(8'd3, 8'd5, 1'b1);
    check("single_in_ready_drain", 32'(in_ready), 32'd0);
    step(); check("single_valid_k1", 32'(out_valid), 32'd0);
    step(); check("single_valid_k2", 32'(out_valid), 32'd0);
    step(); check("single_valid_k3", 32'(out_valid), 32'd1);
    check("single_data",  32'(out_data),  32'd15);
    check("single_count", 32'(out_count), 32'd1);
    handshake();
    check("single_after_hs_valid", 32'(out_valid), 32'd0);
    check("single_after_hs_ready", 32'(in_ready),  32'd1);

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < vecs[v].len; i++) begin
        send_beat(vecs[v].a[i], vecs[v].b[i], i == vecs[v].len - 1);
      end
      check($sformatf("vec%0d_in_ready_drain", v), 32'(in_ready), 32'd0);
      wait_result($sformatf("vec%0d_timeout", v));
      check($sformatf("vec%0d_in_ready_done", v), 32'(in_ready),  32'd0);
      check($sformatf("vec%0d_data", v),          32'(out_data),  32'(vecs[v].exp_data));
      check($sformatf("vec%0d_count", v),         32'(out_count), 32'(vecs[v].exp_cnt));
      handshake();
    end

    // 256 beats of 255x255 fills the guard bits without wrapping.
    for (int i = 0; i < 256; i++) begin
      send_beat(8'd255, 8'd255, i == 255);
    end
    wait_result("full_timeout");
    check("full_data",  32'(out_data),  32'hFE0100);
    check("full_count", 32'(out_count), 32'd256);

    // Back-pressure for 10 cycles: result must hold and input stays blocked.
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall_valid",    32'(out_valid), 32'd1);
      check("stall_data",     32'(out_data),  32'hFE0100);
      check("stall_count",    32'(out_count), 32'd256);
      check("stall_in_ready", 32'(in_ready),  32'd0);
    end
    // Handshake at edge m with the next pair already waiting; accepted at m+1.
    in_valid = 1'b1; in_a = 8'd6; in_b = 8'd7; in_last = 1'b1;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("next_in_ready_m", 32'(in_ready),  32'd1);
    check("next_valid_m",    32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    check("next_accepted_m1", 32'(in_ready), 32'd0);
    wait_result("next_timeout");
    check("next_data",  32'(out_data),  32'd42);
    check("next_count", 32'(out_count), 32'd1);
    handshake();

    // [2,2,2] with two idle cycles between beats.
    for (int i = 0; i < 3; i++) begin
      send_beat(8'd2, 8'd2, i == 2);
      if (i < 2) repeat (2) step();
    end
    wait_result("gap_timeout");
    check("gap_data",  32'(out_data),  32'd12);
    check("gap_count", 32'(out_count), 32'd3);
    handshake();

    // Reset after 2 of 4 beats; in-flight products must be discarded.
    send_beat(8'd100, 8'd100, 1'b0);
    send_beat(8'd50,  8'd50,  1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data",  32'(out_data),  32'd0);
    check("mid_rst_out_count", 32'(out_count), 32'd0);
    send_beat(8'd7, 8'd9, 1'b1);
    wait_result("post_rst_timeout");
    check("post_rst_data",  32'(out_data),  32'd63);
    check("post_rst_count", 32'(out_count), 32'd1);
    handshake();
    for (int i = 0; i < 10; i++) begin
      step();
      check("post_rst_no_extra", 32'(out_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_dot_product_accumulator
